key_reader: RTL and testbench
=============================

// Module: key_reader
// PURPOSE
//  Input-side companion to the LED output drivers. Samples the board's raw active-low push buttons,
//  synchronises and debounces each one, and emits a clean level plus single-cycle press, release and
//  long-press event pulses. Sits between the button pins and any control logic, such as LED pattern select.
// PARAMETERS
//  NUM_KEYS         2           number of independent button channels
//  DEBOUNCE_CYCLES  480_000     consecutive stable sync samples to accept a change (20 ms @ 24 MHz); >=2
//  LONG_CYCLES      24_000_000  cycles held after accepted press before key_long fires (1 s); >=2
// PORTS
//  sys_clk      in   1         24 MHz system clock
//  sys_rst_n    in   1         asynchronous, active-low reset
//  key_n        in   NUM_KEYS  raw button pins, active-low, asynchronous to sys_clk
//  key_level    out  NUM_KEYS  debounced state, 1 = pressed
//  key_press    out  NUM_KEYS  1-cycle pulse on accepted press
//  key_release  out  NUM_KEYS  1-cycle pulse on accepted release
//  key_long     out  NUM_KEYS  1-cycle pulse once per press when held LONG_CYCLES
// BEHAVIOUR
//  - Reset (async assert, sync release by design): sync flops = 1 (released), FSM = IDLE, counters = 0,
//    long_fired = 0, all outputs 0. Reset mid-press: no release pulse. After reset, a held key must be re-debounced.
//  - Per channel: 2-flop synchroniser on key_n; s = synchronised sample (0 = pressed). Channels fully independent.
//  - db_cnt width $clog2(DEBOUNCE_CYCLES); hold_cnt width $clog2(LONG_CYCLES). Neither wraps; both saturate or clear.
//  - FSM states:
//    IDLE:       level 0. s==0 -> DB_PRESS, db_cnt<=0.
//    DB_PRESS:   s==1 -> IDLE, db_cnt<=0, no pulse. s==0 and db_cnt==DEBOUNCE_CYCLES-1 -> PRESSED,
//                key_press=1, level<=1, hold_cnt<=0, long_fired<=0. Otherwise db_cnt++.
//    PRESSED:    s==1 -> DB_RELEASE, db_cnt<=0; hold_cnt frozen. Otherwise, while !long_fired: hold_cnt++.
//                hold_cnt==LONG_CYCLES-1 -> key_long=1, long_fired<=1.
//    DB_RELEASE: level stays 1. s==0 (bounce) -> PRESSED, hold_cnt resumes, no pulse.
//                s==1 and db_cnt==DEBOUNCE_CYCLES-1 -> IDLE, key_release=1, level<=0. Otherwise db_cnt++.
//  - Pulses are registered and high exactly one cycle. key_level changes in the same cycle as the matching pulse.
//  - key_long fires at most once per press. It never fires after release is accepted.
//  - Latency: clean press at raw edge t -> key_press high in cycle t+DEBOUNCE_CYCLES+3
//    (2 sync + 1 state entry + count). Release latency is identical.
//  - A glitch shorter than DEBOUNCE_CYCLES sync samples produces no event and no level change.
//  - A press and a release can never pulse in the same cycle on one channel. Different channels may pulse simultaneously.
// STRUCTURE
//  - Shared header key_defs.vh: FSM state encodings (IDLE, DB_PRESS, PRESSED, DB_RELEASE, 2 bits)
//    and default cycle constants for 24 MHz.
//  - Sub-module key_channel: one synchroniser + FSM + counters, 1-bit ports.
//  - key_reader: generate-loop of NUM_KEYS key_channel instances; no shared logic.
// TESTING (bench uses DEBOUNCE_CYCLES=4, LONG_CYCLES=16, NUM_KEYS=2)
//  - Reset: hold sys_rst_n=0 with key_n=2'b00 -> all outputs 0. Release reset, keep keys low ->
//    key_press pulses 7 cycles later and key_level=1.
//  - Clean press/release on key 0: key_n[0] low for 10 cycles, then high ->
//    key_press[0] at +7, key_release[0] 7 cycles after rise. key_long never fires. Key 1 outputs stay 0.
//  - Bounce: 3-cycle low glitches separated by 1-cycle highs, then stable low -> exactly one key_press,
//    7 cycles after the final fall. Same pattern on release -> exactly one key_release.
//  - Long press: hold low for 40 cycles -> key_press at +7, key_long exactly 16 cycles later and only once.
//    A 2-cycle release bounce at hold_cnt=10 delays key_long by 2 cycles.
//  - Reset mid-hold: assert reset while key_level=1 -> all outputs 0 asynchronously and no key_release pulse.
//    After reset, held key re-debounces to key_press after 7 cycles.
//  - Simultaneous: both keys pressed on the same edge -> key_press=2'b11 in the same cycle.

Source files
------------

// File: rtl/key_reader_pkg.sv
// Shared types and default timing constants for the push-button reader.
// Defaults assume a 24 MHz system clock.
package key_reader_pkg;

  // Per-channel debounce FSM states
  typedef enum logic [1:0] {
    StIdle      = 2'b00,
    StDbPress   = 2'b01,
    StPressed   = 2'b10,
    StDbRelease = 2'b11
  } key_state_e;

  localparam int unsigned DefaultNumKeys        = 2;
  localparam int unsigned DefaultDebounceCycles = 480_000;     // 20 ms
  localparam int unsigned DefaultLongCycles     = 24_000_000;  // 1 s

endpackage

// File: rtl/key_channel.sv
// One push-button channel: 2-flop synchroniser, debounce FSM, hold counter and
// registered level / press / release / long-press outputs.
module key_channel
  import key_reader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned LONG_CYCLES     = DefaultLongCycles
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HoldW = $clog2(LONG_CYCLES);

  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);

  logic sync1_q, sync2_q;
  logic s;

  key_state_e       state_q, state_d;
  logic [DbW-1:0]   db_cnt_q, db_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             long_fired_q, long_fired_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             hold_adv;

  // Sync flops reset to 1 so a key held through reset must be re-debounced
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_ni;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;

  always_comb begin
    state_d      = state_q;
    db_cnt_d     = db_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    long_fired_d = long_fired_q;
    level_d      = level_q;
    press_d      = 1'b0;
    release_d    = 1'b0;
    long_d       = 1'b0;
    hold_adv     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!s) begin
          state_d  = StDbPress;
          db_cnt_d = '0;
        end
      end
      StDbPress: begin
        if (s) begin
          state_d  = StIdle;
          db_cnt_d = '0;
        end else if (db_cnt_q == DbLast) begin
          state_d      = StPressed;
          press_d      = 1'b1;
          level_d      = 1'b1;
          hold_cnt_d   = '0;
          long_fired_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      StPressed: begin
        if (s) begin
          state_d  = StDbRelease;
          db_cnt_d = '0;
        end else begin
          hold_adv = 1'b1;
        end
      end
      StDbRelease: begin
        if (!s) begin
          // Release bounce: back to held, and this sample still counts as held time
          state_d  = StPressed;
          hold_adv = 1'b1;
        end else if (db_cnt_q == DbLast) begin
          state_d   = StIdle;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Hold counter saturates at its last value; long_fired blocks a second pulse
    if (hold_adv && !long_fired_q) begin
      if (hold_cnt_q == HoldLast) begin
        long_d       = 1'b1;
        long_fired_d = 1'b1;
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      db_cnt_q     <= '0;
      hold_cnt_q   <= '0;
      long_fired_q <= 1'b0;
      level_q      <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      db_cnt_q     <= db_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      long_fired_q <= long_fired_d;
      level_q      <= level_d;
      press_q      <= press_d;
      release_q    <= release_d;
      long_q       <= long_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/key_reader.sv
// Debounced reader for NUM_KEYS active-low push buttons; each channel is
// fully independent.
module key_reader
  import key_reader_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = DefaultNumKeys,
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned LONG_CYCLES     = DefaultLongCycles
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_channel (
      .clk_i    (sys_clk),
      .rst_ni   (sys_rst_n),
      .key_ni   (key_n[g]),
      .level_o  (key_level[g]),
      .press_o  (key_press[g]),
      .release_o(key_release[g]),
      .long_o   (key_long[g])
    );
  end

endmodule

// File: tb/tb_key_reader.sv
// Self-checking bench for key_reader: directed scenarios plus randomized
// button activity against a run-length based reference model.
module tb_key_reader;

  localparam int unsigned Db   = 4;
  localparam int unsigned Long = 16;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [1:0] key_n;
  logic [1:0] key_level, key_press, key_release, key_long;

  key_reader #(
    .NUM_KEYS       (2),
    .DEBOUNCE_CYCLES(Db),
    .LONG_CYCLES    (Long)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_n      (key_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: sampled value is the raw pin two clocks earlier. A change is
  // accepted once the sampled value has been steady for Db+1 consecutive samples;
  // long fires on the Long-th pressed sample after acceptance.
  logic [1:0] m_f1, m_f2;
  int         m_run0 [2];
  int         m_run1 [2];
  int         m_held [2];
  logic [1:0] m_fired;
  logic [1:0] m_level, m_press, m_release, m_long;

  task automatic model_reset();
    m_f1 = 2'b11;
    m_f2 = 2'b11;
    m_fired = '0;
    m_level = '0;
    m_press = '0;
    m_release = '0;
    m_long = '0;
    for (int i = 0; i < 2; i++) begin
      m_run0[i] = 0;
      m_run1[i] = 0;
      m_held[i] = 0;
    end
  endtask

  task automatic model_step(input logic [1:0] raw);
    logic sv;
    for (int i = 0; i < 2; i++) begin
      sv = m_f2[i];
      m_f2[i] = m_f1[i];
      m_f1[i] = raw[i];
      if (sv) begin
        m_run1[i] = (m_run1[i] < 1000) ? m_run1[i] + 1 : 1000;
        m_run0[i] = 0;
      end else begin
        m_run0[i] = (m_run0[i] < 1000) ? m_run0[i] + 1 : 1000;
        m_run1[i] = 0;
      end
      m_press[i]   = !m_level[i] && (m_run0[i] == Db + 1);
      m_release[i] = m_level[i] && (m_run1[i] == Db + 1);
      m_long[i]    = 1'b0;
      if (m_level[i] && !sv && !m_fired[i]) begin
        m_held[i]++;
        if (m_held[i] == Long) begin
          m_long[i]  = 1'b1;
          m_fired[i] = 1'b1;
        end
      end
      if (m_press[i]) begin
        m_level[i] = 1'b1;
        m_held[i]  = 0;
        m_fired[i] = 1'b0;
      end
      if (m_release[i]) m_level[i] = 1'b0;
    end
  endtask

  // Drive at a falling edge, step the model on the rising edge, return at the next falling edge
  task automatic tick(input logic [1:0] raw);
    key_n = raw;
    @(posedge sys_clk);
    model_step(raw);
    @(negedge sys_clk);
    cyc++;
  endtask

  task automatic settle(input logic [1:0] raw, input int n);
    for (int i = 0; i < n; i++) tick(raw);
  endtask

  task automatic test_reset();
    int first_press;
    sys_rst_n = 1'b0;
    key_n = 2'b00;
    model_reset();
    repeat (3) @(negedge sys_clk);
    n_cmp++;
    if ({key_level, key_press, key_release, key_long} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_outputs got=%b want=00000000",
               {key_level, key_press, key_release, key_long});
    end
    sys_rst_n = 1'b1;
    first_press = -1;
    for (int t = 1; t <= 10; t++) begin
      tick(2'b00);
      n_cmp++;
      if ({key_level, key_press, key_release, key_long} !==
          {m_level, m_press, m_release, m_long}) begin
        n_bad++;
        $display("FAIL reset_model cyc=%0d got=%b want=%b", cyc,
                 {key_level, key_press, key_release, key_long},
                 {m_level, m_press, m_release, m_long});
      end
      if (key_press == 2'b11 && first_press < 0) first_press = t;
    end
    n_cmp++;
    if (first_press != 7) begin
      n_bad++;
      $display("FAIL reset_press_latency got=%0d want=7", first_press);
    end
    n_cmp++;
    if (key_level !== 2'b11) begin
      n_bad++;
      $display("FAIL reset_level got=%b want=11", key_level);
    end
  endtask

  task automatic test_clean();
    int np, nr, nl, k1, press_t, rel_t;
    settle(2'b11, 12);
    np = 0; nr = 0; nl = 0; k1 = 0; press_t = -1; rel_t = -1;
    for (int t = 1; t <= 25; t++) begin
      tick((t <= 10) ? 2'b10 : 2'b11);
      n_cmp++;
      if ({key_level, key_press, key_release, key_long} !==
          {m_level, m_press, m_release, m_long}) begin
        n_bad++;
        $display("FAIL clean_model cyc=%0d got=%b want=%b", cyc,
                 {key_level, key_press, key_release, key_long},
                 {m_level, m_press, m_release, m_long});
      end
      if (key_press[0]) begin np++; press_t = t; end
      if (key_release[0]) begin nr++; rel_t = t; end
      if (key_long != 2'b00) nl++;
      if ({key_level[1], key_press[1], key_release[1], key_long[1]} != 4'b0000) k1++;
    end
    n_cmp++;
    if (np != 1 || press_t != 7) begin
      n_bad++;
      $display("FAIL clean_press got count=%0d at=%0d want count=1 at=7", np, press_t);
    end
    n_cmp++;
    if (nr != 1 || rel_t != 17) begin
      n_bad++;
      $display("FAIL clean_release got count=%0d at=%0d want count=1 at=17", nr, rel_t);
    end
    n_cmp++;
    if (nl != 0 || k1 != 0) begin
      n_bad++;
      $display("FAIL clean_quiet got long=%0d key1_active=%0d want 0 and 0", nl, k1);
    end
  endtask

  task automatic test_bounce();
    bit q[$];
    int fall_t, rise_t, np, nr, press_t, rel_t;
    settle(2'b11, 12);
    for (int k = 0; k < 3; k++) begin
      repeat (3) q.push_back(1'b0);
      q.push_back(1'b1);
    end
    fall_t = q.size() + 1;
    repeat (12) q.push_back(1'b0);
    for (int k = 0; k < 3; k++) begin
      repeat (3) q.push_back(1'b1);
      q.push_back(1'b0);
    end
    rise_t = q.size() + 1;
    repeat (14) q.push_back(1'b1);
    np = 0; nr = 0; press_t = -1; rel_t = -1;
    for (int t = 1; t <= q.size(); t++) begin
      tick({1'b1, q[t-1]});
      n_cmp++;
      if ({key_level, key_press, key_release, key_long} !==
          {m_level, m_press, m_release, m_long}) begin
        n_bad++;
        $display("FAIL bounce_model cyc=%0d got=%b want=%b", cyc,
                 {key_level, key_press, key_release, key_long},
                 {m_level, m_press, m_release, m_long});
      end
      if (key_press[0]) begin np++; press_t = t; end
      if (key_release[0]) begin nr++; rel_t = t; end
    end
    n_cmp++;
    if (np != 1 || press_t != fall_t + 6) begin
      n_bad++;
      $display("FAIL bounce_press got count=%0d at=%0d want count=1 at=%0d",
               np, press_t, fall_t + 6);
    end
    n_cmp++;
    if (nr != 1 || rel_t != rise_t + 6) begin
      n_bad++;
      $display("FAIL bounce_release got count=%0d at=%0d want count=1 at=%0d",
               nr, rel_t, rise_t + 6);
    end
  endtask

  task automatic test_long();
    int press_t, long_t, nl;
    for (int pass = 0; pass < 2; pass++) begin
      settle(2'b11, 12);
      press_t = -1; long_t = -1; nl = 0;
      for (int t = 1; t <= 52; t++) begin
        // Second pass: two raw high cycles landing while hold_cnt is 10
        if (t > 40 || (pass == 1 && (t == 16 || t == 17))) tick(2'b11);
        else tick(2'b10);
        n_cmp++;
        if ({key_level, key_press, key_release, key_long} !==
            {m_level, m_press, m_release, m_long}) begin
          n_bad++;
          $display("FAIL long_model pass=%0d cyc=%0d got=%b want=%b", pass, cyc,
                   {key_level, key_press, key_release, key_long},
                   {m_level, m_press, m_release, m_long});
        end
        if (key_press[0] && press_t < 0) press_t = t;
        if (key_long[0]) begin nl++; long_t = t; end
      end
      n_cmp++;
      if (press_t != 7) begin
        n_bad++;
        $display("FAIL long_press pass=%0d got=%0d want=7", pass, press_t);
      end
      n_cmp++;
      if (nl != 1 || long_t != (pass == 0 ? 23 : 25)) begin
        n_bad++;
        $display("FAIL long_fire pass=%0d got count=%0d at=%0d want count=1 at=%0d",
                 pass, nl, long_t, (pass == 0 ? 23 : 25));
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    int press_t, nrel;
    settle(2'b11, 12);
    settle(2'b00, 10);
    n_cmp++;
    if (key_level !== 2'b11) begin
      n_bad++;
      $display("FAIL midhold_level_before got=%b want=11", key_level);
    end
    #2;
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({key_level, key_press, key_release, key_long} !== 8'h00) begin
      n_bad++;
      $display("FAIL midhold_async_clear got=%b want=00000000",
               {key_level, key_press, key_release, key_long});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      n_cmp++;
      if ({key_level, key_press, key_release, key_long} !== 8'h00) begin
        n_bad++;
        $display("FAIL midhold_in_reset got=%b want=00000000",
                 {key_level, key_press, key_release, key_long});
      end
    end
    sys_rst_n = 1'b1;
    press_t = -1; nrel = 0;
    for (int t = 1; t <= 12; t++) begin
      tick(2'b00);
      n_cmp++;
      if ({key_level, key_press, key_release, key_long} !==
          {m_level, m_press, m_release, m_long}) begin
        n_bad++;
        $display("FAIL midhold_model cyc=%0d got=%b want=%b", cyc,
                 {key_level, key_press, key_release, key_long},
                 {m_level, m_press, m_release, m_long});
      end
      if (key_press == 2'b11 && press_t < 0) press_t = t;
      if (key_release != 2'b00) nrel++;
    end
    n_cmp++;
    if (press_t != 7 || nrel != 0) begin
      n_bad++;
      $display("FAIL midhold_redebounce got press_at=%0d releases=%0d want 7 and 0",
               press_t, nrel);
    end
  endtask

  task automatic test_simultaneous();
    int t_ev;
    logic [1:0] v_ev;
    settle(2'b11, 12);
    t_ev = -1; v_ev = 2'b00;
    for (int t = 1; t <= 12; t++) begin
      tick(2'b00);
      if (key_press != 2'b00 && t_ev < 0) begin t_ev = t; v_ev = key_press; end
    end
    n_cmp++;
    if (v_ev !== 2'b11 || t_ev != 7) begin
      n_bad++;
      $display("FAIL simul_press got=%b at=%0d want=11 at=7", v_ev, t_ev);
    end
    t_ev = -1; v_ev = 2'b00;
    for (int t = 1; t <= 12; t++) begin
      tick(2'b11);
      if (key_release != 2'b00 && t_ev < 0) begin t_ev = t; v_ev = key_release; end
    end
    n_cmp++;
    if (v_ev !== 2'b11 || t_ev != 7) begin
      n_bad++;
      $display("FAIL simul_release got=%b at=%0d want=11 at=7", v_ev, t_ev);
    end
  endtask

  task automatic test_random();
    logic [1:0] raw;
    int len [2];
    raw = 2'b11;
    len[0] = 0;
    len[1] = 0;
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < 2; i++) begin
        if (len[i] == 0) begin
          raw[i] = ~raw[i];
          len[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 8);
        end
        len[i]--;
      end
      tick(raw);
      n_cmp++;
      if ({key_level, key_press, key_release, key_long} !==
          {m_level, m_press, m_release, m_long}) begin
        n_bad++;
        $display("FAIL random_model cyc=%0d raw=%b got=%b want=%b", cyc, raw,
                 {key_level, key_press, key_release, key_long},
                 {m_level, m_press, m_release, m_long});
      end
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    key_n = 2'b11;
    test_reset();
    test_clean();
    test_bounce();
    test_long();
    test_reset_mid_hold();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
